// File: rtl/gpu_mem_pkg.sv
// Shared VRAM fill types: state encoding, bus widths and line-address geometry.
// No logic here; imported by the fill controller and its beat counter.
package gpu_mem_pkg;

    localparam int VRAM_ADR_W      = 17;
    localparam int BEAT_W          = 64;
    localparam int CLUT_LINE_SHIFT = 2;
    localparam int TEX_ADR_W       = 17;
    localparam int CLUT_ADR_W      = 15;
    localparam int LEN_W           = 3;
    localparam int BEAT_CNT_W      = 2;

    typedef enum logic [2:0] {
        FILL_IDLE,
        FILL_REQ_T,
        FILL_REQ_C,
        FILL_DATA_T,
        FILL_DATA_C,
        FILL_DONE_T,
        FILL_DONE_C,
        FILL_HOLD
    } fillState_t;

endpackage

// File: rtl/gpu_fill_beat_counter.sv
// Beat index within a line fill: load clears, inc advances, isLast flags the final beat.
// Registered count, combinational compare; no backpressure, caller qualifies inc.
module gpu_fill_beat_counter
    import gpu_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  inc,
    input  logic [BEAT_CNT_W-1:0] lastIdx,
    output logic [BEAT_CNT_W-1:0] count,
    output logic                  isLast
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign isLast = (count == lastIdx);

endmodule

// File: rtl/gpu_cache_fill_ctrl.sv
// Arbitrates Tex$/Clut$ miss refills onto the VRAM read port and streams beats into the owning cache.
// Request issued the cycle after a miss is sampled, held until ack; beats written same cycle they arrive.
module gpu_cache_fill_ctrl
    import gpu_mem_pkg::*;
#(
    parameter int TEX_BEATS  = 1,
    parameter int CLUT_BEATS = 4,
    parameter int HOLDOFF    = 1
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_texMissRequ,
    input  logic [TEX_ADR_W-1:0]  i_texMissAdr,
    input  logic                  i_clutMissRequ,
    input  logic [CLUT_ADR_W-1:0] i_clutMissAdr,
    output logic                  o_pause,
    output logic                  o_texUpdateDone,
    output logic                  o_clutUpdateDone,
    output logic                  o_memRequ,
    output logic [VRAM_ADR_W-1:0] o_memAdr,
    output logic [LEN_W-1:0]      o_memLen,
    input  logic                  i_memAck,
    input  logic                  i_memDataValid,
    input  logic [BEAT_W-1:0]     i_memData,
    output logic                  o_texWrite,
    output logic [TEX_ADR_W-1:0]  o_texWrAdr,
    output logic                  o_clutWrite,
    output logic [CLUT_ADR_W-1:0] o_clutWrAdr,
    output logic [BEAT_CNT_W-1:0] o_clutWrBeat,
    output logic [BEAT_W-1:0]     o_cacheWrData
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    if (CLUT_BEATS > 4 || CLUT_BEATS < 1 || TEX_BEATS != 1 || HOLDOFF < 1) begin : gParamCheck
        $error("gpu_cache_fill_ctrl: unsupported beat count or holdoff");
    end

    fillState_t            state;
    fillState_t            nextState;
    logic [VRAM_ADR_W-1:0] fillAdr;
    logic [LEN_W-1:0]      fillLen;
    logic [TEX_ADR_W-1:0]  texAdrQ;
    logic [CLUT_ADR_W-1:0] clutAdrQ;
    logic [HOLD_W-1:0]     holdCnt;
    logic                  latchTex;
    logic                  latchClut;
    logic                  beatLoad;
    logic                  beatInc;
    logic                  beatLast;
    logic [BEAT_CNT_W-1:0] beatCnt;

    gpu_fill_beat_counter uBeatCnt (
        .clk     (clk),
        .rst     (i_rst),
        .load    (beatLoad),
        .inc     (beatInc),
        .lastIdx (BEAT_CNT_W'(fillLen - LEN_W'(1))),
        .count   (beatCnt),
        .isLast  (beatLast)
    );

    always_comb begin
        nextState        = state;
        latchTex         = 1'b0;
        latchClut        = 1'b0;
        beatLoad         = 1'b0;
        beatInc          = 1'b0;
        o_memRequ        = 1'b0;
        o_texWrite       = 1'b0;
        o_clutWrite      = 1'b0;
        o_texUpdateDone  = 1'b0;
        o_clutUpdateDone = 1'b0;
        case (state)
            // Clut wins a tie: a palette miss blocks the texel lookup that needs it.
            FILL_IDLE: begin
                if (i_clutMissRequ) begin
                    latchClut = 1'b1;
                    nextState = FILL_REQ_C;
                end else if (i_texMissRequ) begin
                    latchTex  = 1'b1;
                    nextState = FILL_REQ_T;
                end
            end
            FILL_REQ_T, FILL_REQ_C: begin
                o_memRequ = 1'b1;
                if (i_memAck) begin
                    beatLoad  = 1'b1;
                    nextState = (state == FILL_REQ_C) ? FILL_DATA_C : FILL_DATA_T;
                end
            end
            FILL_DATA_T: begin
                if (i_memDataValid) begin
                    o_texWrite = 1'b1;
                    beatInc    = 1'b1;
                    if (beatLast) nextState = FILL_DONE_T;
                end
            end
            FILL_DATA_C: begin
                if (i_memDataValid) begin
                    o_clutWrite = 1'b1;
                    beatInc     = 1'b1;
                    if (beatLast) nextState = FILL_DONE_C;
                end
            end
            FILL_DONE_T: begin
                o_texUpdateDone = 1'b1;
                nextState       = FILL_HOLD;
            end
            FILL_DONE_C: begin
                o_clutUpdateDone = 1'b1;
                nextState        = FILL_HOLD;
            end
            // Gives C1 time to re-look-up and drop a miss that the fill just satisfied.
            FILL_HOLD: begin
                if (holdCnt == HOLD_W'(HOLDOFF - 1)) nextState = FILL_IDLE;
            end
            default: nextState = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state    <= FILL_IDLE;
            fillAdr  <= '0;
            fillLen  <= '0;
            texAdrQ  <= '0;
            clutAdrQ <= '0;
            holdCnt  <= '0;
        end else begin
            state   <= nextState;
            holdCnt <= (state == FILL_HOLD) ? holdCnt + 1'b1 : '0;
            if (latchTex) begin
                texAdrQ <= i_texMissAdr;
                fillAdr <= i_texMissAdr;
                fillLen <= LEN_W'(TEX_BEATS);
            end
            if (latchClut) begin
                clutAdrQ <= i_clutMissAdr;
                fillAdr  <= {i_clutMissAdr, {CLUT_LINE_SHIFT{1'b0}}};
                fillLen  <= LEN_W'(CLUT_BEATS);
            end
        end
    end

    assign o_pause       = (state != FILL_IDLE) | i_texMissRequ | i_clutMissRequ;
    assign o_memAdr      = o_memRequ ? fillAdr : '0;
    assign o_memLen      = o_memRequ ? fillLen : '0;
    assign o_texWrAdr    = o_texWrite ? texAdrQ : '0;
    assign o_clutWrAdr   = o_clutWrite ? clutAdrQ : '0;
    assign o_clutWrBeat  = o_clutWrite ? beatCnt : '0;
    assign o_cacheWrData = (o_texWrite | o_clutWrite) ? i_memData : '0;

endmodule

// File: tb/tb_gpu_cache_fill_ctrl.sv
// Randomized bench for gpu_cache_fill_ctrl: pipeline/VRAM stand-in with a fill-order model.
// Expected grants come from the priority and address-mapping rules, expected writes from the beats sent.
module tb_gpu_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        texReq;
    logic [16:0] texAdr;
    logic        clutReq;
    logic [14:0] clutAdr;
    logic        memAck;
    logic        memValid;
    logic [63:0] memData;

    logic        o_pause, o_texUpdateDone, o_clutUpdateDone, o_memRequ;
    logic [16:0] o_memAdr;
    logic [2:0]  o_memLen;
    logic        o_texWrite, o_clutWrite;
    logic [16:0] o_texWrAdr;
    logic [14:0] o_clutWrAdr;
    logic [1:0]  o_clutWrBeat;
    logic [63:0] o_cacheWrData;

    always #5 clk = ~clk;

    gpu_cache_fill_ctrl #(.TEX_BEATS(1), .CLUT_BEATS(4), .HOLDOFF(1)) dut (
        .clk              (clk),
        .i_rst            (rst),
        .i_texMissRequ    (texReq),
        .i_texMissAdr     (texAdr),
        .i_clutMissRequ   (clutReq),
        .i_clutMissAdr    (clutAdr),
        .o_pause          (o_pause),
        .o_texUpdateDone  (o_texUpdateDone),
        .o_clutUpdateDone (o_clutUpdateDone),
        .o_memRequ        (o_memRequ),
        .o_memAdr         (o_memAdr),
        .o_memLen         (o_memLen),
        .i_memAck         (memAck),
        .i_memDataValid   (memValid),
        .i_memData        (memData),
        .o_texWrite       (o_texWrite),
        .o_texWrAdr       (o_texWrAdr),
        .o_clutWrite      (o_clutWrite),
        .o_clutWrAdr      (o_clutWrAdr),
        .o_clutWrBeat     (o_clutWrBeat),
        .o_cacheWrData    (o_cacheWrData)
    );

    typedef struct {
        bit          isClut;
        logic [16:0] adr;
    } fill_t;

    int          nVectors     = 0;
    int          nMiscompares = 0;
    int          ackDlyFix    = -1;
    int          gapFix       = -1;
    bit          useDataFix   = 1'b0;
    logic [63:0] dataFix      = '0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllQuiet(input string tag);
        checkVal(tag, {o_pause, o_texUpdateDone, o_clutUpdateDone, o_memRequ, o_memAdr, o_memLen,
                       o_texWrite, o_texWrAdr, o_clutWrite, o_clutWrAdr, o_clutWrBeat}, 64'd0);
        checkVal({tag, "Data"}, o_cacheWrData, 64'd0);
    endtask

    // One refill as seen from the pipeline and VRAM: grant, ack, beats, done, hold.
    task automatic runFill(input bit isClut, input logic [16:0] adr, input bit keep, input int rstAt);
        logic [16:0] expAdr;
        int          len;
        bit          seen;
        int          dly;
        int          gap;
        logic [63:0] d;
        expAdr = isClut ? {adr[14:0], 2'b00} : adr;
        len    = isClut ? 4 : 1;
        seen   = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            memValid = 1'($urandom_range(0, 1));
            memData  = {$urandom, $urandom};
            @(negedge clk);
            checkVal("strayWr", {o_texWrite, o_clutWrite}, 64'd0);
            checkVal("pauseMiss", o_pause, 64'd1);
            if (o_memRequ) seen = 1'b1;
            else nextCyc();
        end
        checkVal("reqSeen", seen, 64'd1);
        if (!seen) begin
            memValid = 1'b0;
            return;
        end
        checkVal("memAdr", o_memAdr, expAdr);
        checkVal("memLen", o_memLen, 64'(len));
        dly = (ackDlyFix >= 0) ? ackDlyFix : $urandom_range(0, 3);
        for (int i = 0; i < dly; i++) begin
            nextCyc();
            memValid = 1'($urandom_range(0, 1));
            memData  = {$urandom, $urandom};
            @(negedge clk);
            checkVal("reqHold", o_memRequ, 64'd1);
            checkVal("adrHold", o_memAdr, expAdr);
            checkVal("strayWrReq", {o_texWrite, o_clutWrite}, 64'd0);
        end
        memAck   = 1'b1;
        memValid = 1'b0;
        nextCyc();
        memAck = 1'b0;
        for (int b = 0; b < len; b++) begin
            gap = (gapFix >= 0) ? gapFix : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checkVal("gapWr", {o_texWrite, o_clutWrite}, 64'd0);
                checkVal("pauseFill", o_pause, 64'd1);
                nextCyc();
            end
            if (b == rstAt) begin
                rst     = 1'b1;
                texReq  = 1'b0;
                clutReq = 1'b0;
                nextCyc();
                rst = 1'b0;
                @(negedge clk);
                checkAllQuiet("rstMidFill");
                nextCyc();
                @(negedge clk);
                checkVal("rstNoDone", {o_memRequ, o_texUpdateDone, o_clutUpdateDone}, 64'd0);
                nextCyc();
                return;
            end
            d        = useDataFix ? dataFix + 64'(b) : {$urandom, $urandom};
            memValid = 1'b1;
            memData  = d;
            @(negedge clk);
            if (isClut) begin
                checkVal("clutWr", {o_clutWrite, o_texWrite}, 64'b10);
                checkVal("clutWrAdr", o_clutWrAdr, adr[14:0]);
                checkVal("clutWrBeat", o_clutWrBeat, 64'(b));
            end else begin
                checkVal("texWr", {o_texWrite, o_clutWrite}, 64'b10);
                checkVal("texWrAdr", o_texWrAdr, adr);
            end
            checkVal("wrData", o_cacheWrData, d);
            checkVal("earlyDone", {o_texUpdateDone, o_clutUpdateDone}, 64'd0);
            nextCyc();
            memValid = 1'b0;
        end
        @(negedge clk);
        checkVal("doneStrobe", {o_texUpdateDone, o_clutUpdateDone}, isClut ? 64'b01 : 64'b10);
        checkVal("donePause", o_pause, 64'd1);
        nextCyc();
        if (!keep) begin
            if (isClut) clutReq = 1'b0;
            else texReq = 1'b0;
        end
        @(negedge clk);
        checkVal("holdQuiet", {o_memRequ, o_texUpdateDone, o_clutUpdateDone}, 64'd0);
        checkVal("holdPause", o_pause, 64'd1);
        nextCyc();
    endtask

    task automatic checkReleased();
        @(negedge clk);
        checkVal("pauseRelease", {o_pause, o_memRequ}, 64'd0);
        nextCyc();
    endtask

    initial begin
        fill_t q[$];
        fill_t f;
        bit    keepUsed;
        bit    wantKeep;
        int    kind;

        rst      = 1'b1;
        texReq   = 1'b0;
        texAdr   = '0;
        clutReq  = 1'b0;
        clutAdr  = '0;
        memAck   = 1'b0;
        memValid = 1'b0;
        memData  = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllQuiet("resetOuts");
        nextCyc();

        // Single tex miss, ack after three cycles.
        ackDlyFix  = 3;
        useDataFix = 1'b1;
        dataFix    = 64'hDEAD;
        texAdr     = 17'h1ABCD;
        texReq     = 1'b1;
        runFill(1'b0, 17'h1ABCD, 1'b0, -1);
        checkReleased();

        // Clut miss, one idle cycle between beats.
        ackDlyFix  = -1;
        useDataFix = 1'b0;
        gapFix     = 1;
        clutAdr    = 15'h4C21;
        clutReq    = 1'b1;
        runFill(1'b1, 17'h04C21, 1'b0, -1);
        checkReleased();
        gapFix = -1;

        // Both misses together: clut first, then tex straight after hold.
        texAdr  = 17'h0F0F1;
        clutAdr = 15'h7FFF;
        texReq  = 1'b1;
        clutReq = 1'b1;
        runFill(1'b1, 17'h07FFF, 1'b0, -1);
        runFill(1'b0, 17'h0F0F1, 1'b0, -1);
        checkReleased();

        // Reset in the middle of a clut fill, then a normal tex fill.
        clutAdr = 15'h1234;
        clutReq = 1'b1;
        runFill(1'b1, 17'h01234, 1'b0, 2);
        texAdr = 17'h00042;
        texReq = 1'b1;
        runFill(1'b0, 17'h00042, 1'b0, -1);
        checkReleased();

        // Stale miss level left high through hold gets re-granted.
        texAdr = 17'h15555;
        texReq = 1'b1;
        runFill(1'b0, 17'h15555, 1'b1, -1);
        runFill(1'b0, 17'h15555, 1'b0, -1);
        checkReleased();

        for (int t = 0; t < 40; t++) begin
            kind     = $urandom_range(0, 2);
            texAdr   = 17'($urandom);
            clutAdr  = 15'($urandom);
            wantKeep = ($urandom_range(0, 3) == 0);
            keepUsed = 1'b0;
            q.delete();
            if (kind != 0) q.push_back('{1'b1, {2'b00, clutAdr}});
            if (kind != 1) q.push_back('{1'b0, texAdr});
            clutReq = (kind != 0);
            texReq  = (kind != 1);
            while (q.size() > 0) begin
                f = q.pop_front();
                if (wantKeep && !keepUsed) begin
                    keepUsed = 1'b1;
                    runFill(f.isClut, f.adr, 1'b1, -1);
                    q.push_front(f);
                end else begin
                    runFill(f.isClut, f.adr, 1'b0, -1);
                end
            end
            checkReleased();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
